regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; power of two, >= 2.
REQ-003 Parameter NRP, default 2: number of read ports, 1..4.
REQ-004 Parameter NWP, default 2: number of write ports, 1..2.
REQ-005 Derived constant AW = clog2(NREG); CW = clog2(NREG+1).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 rd_addr_i  in  NRP*AW  read addresses; port p in slice p.
REQ-009 rd_data_o  out  NRP*XLEN  read data per port, combinational.
REQ-010 rd_busy_o  out  NRP  per-port pending-write (scoreboard) flag, combinational.
REQ-011 wr_en_i  in  NWP  write enables.
REQ-012 wr_addr_i  in  NWP*AW  write addresses.
REQ-013 wr_data_i  in  NWP*XLEN  write data.
REQ-014 iss_en_i  in  1  issue strobe: marks iss_addr_i as having a write in flight.
REQ-015 iss_addr_i  in  AW  destination register of the issuing instruction.
REQ-016 busy_cnt_o  out  CW  number of registers currently marked busy, registered.

Function
REQ-017 Address 0 SHALL read as zero, SHALL ignore writes and SHALL never be marked busy.
REQ-018 Read path SHALL be combinational; a read matching an enabled same-cycle write (addr != 0) SHALL return that write data (bypass).
REQ-019 Multiple enabled writes to one address in the same cycle: highest-index write port SHALL win, for both the array update and the bypass.
REQ-020 Enabled writes SHALL update the array on the next rising edge; writes to distinct addresses SHALL all commit.
REQ-021 Scoreboard: busy[a] SHALL be set on the edge after iss_en_i with iss_addr_i == a (a != 0).
REQ-022 busy[a] SHALL be cleared on the edge after any enabled write to a.
REQ-023 Issue and write to the same address in the same cycle: busy SHALL end set (new producer wins).
REQ-024 rd_busy_o[p] SHALL equal busy[rd_addr p] AND NOT (enabled write to that address this cycle); 0 for address 0.
REQ-025 busy_cnt_o SHALL equal the population count of busy[] after each edge; range 0..NREG-1; never wraps.
REQ-026 Issue to an already-busy register SHALL leave it busy and busy_cnt_o unchanged.
REQ-027 Write to a non-busy register SHALL commit data and leave busy_cnt_o unchanged.

Reset
REQ-028 While rst == 0 at a rising edge, every array entry 0..NREG-1 (including the last) SHALL become 0, every busy bit 0, busy_cnt_o 0.
REQ-029 While rst == 0, rd_data_o and rd_busy_o SHALL be forced to 0 regardless of inputs.
REQ-030 Writes and issues presented during reset SHALL be discarded; reset mid-operation SHALL drop all pending busy state.

Structure
REQ-031 Shared package SHALL hold defaults for XLEN, NREG and the clog2 helper; no typedefs beyond these.
REQ-032 One sub-module regfile_sb_fwd SHALL implement the per-read-port bypass/priority mux, instantiated NRP times.
REQ-033 Storage and scoreboard SHALL live in regfile_sb; no latches; busy_cnt_o from a registered counter, not recomputed combinationally.

Verification
REQ-034 Reset then read all addresses -> all rd_data_o 0, rd_busy_o 0, busy_cnt_o 0; including address NREG-1.
REQ-035 Write port0 addr 5 = 0xDEADBEEF, read addr 5 same cycle -> 0xDEADBEEF bypassed; next cycle -> 0xDEADBEEF from array.
REQ-036 Port0 and port1 both write addr 7 (0x11, 0x22) -> same-cycle read 0x22; stored value 0x22.
REQ-037 Issue addr 3 -> rd_busy 1, busy_cnt_o 1; write addr 3 = 0x55 -> same-cycle rd_busy 0; next cycle busy_cnt_o 0.
REQ-038 Issue and write addr 9 same cycle -> next cycle busy[9] 1, data updated, busy_cnt_o +1; write/issue addr 0 -> reads 0, never busy.
REQ-039 Issue addr 4 and 6, assert rst one cycle -> busy_cnt_o 0, rd_busy 0, regs 0; issue/write asserted in that cycle has no effect.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg -- shared defaults for the scoreboarded register file.
//   DEF_XLEN : default data width in bits
//   DEF_NREG : default number of architectural registers
//   clog2()  : ceiling log2, usable in parameter/localparam expressions
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_fwd.sv
// regfile_sb_fwd -- per-read-port bypass and write-priority mux.
//   rd_addr  : address being read on this port
//   arr_data : current array contents at rd_addr
//   wr_en    : write enables, one per write port
//   wr_addr  : packed write addresses, port w in slice w
//   wr_data  : packed write data, port w in slice w
//   rd_data  : bypassed read data (zero for address 0)
//   hit      : an enabled same-cycle write targets rd_addr (never for address 0)
module regfile_sb_fwd #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWP  = 2
) (
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     arr_data,
    input  logic [NWP-1:0]      wr_en,
    input  logic [NWP*AW-1:0]   wr_addr,
    input  logic [NWP*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rd_data,
    output logic                hit
);

    // Ascending scan: a later (higher-index) matching port overrides earlier
    // ones, matching the commit order of the array.
    always_comb begin
        rd_data = arr_data;
        hit     = 1'b0;
        for (int w = 0; w < NWP; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
                rd_data = wr_data[w*XLEN +: XLEN];
                hit     = 1'b1;
            end
        end
        if (rd_addr == '0) begin
            rd_data = '0;
            hit     = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port register file with a pending-write scoreboard.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-low reset
//   rd_addr_i  : NRP packed read addresses
//   rd_data_o  : NRP packed read data (combinational, write-bypassed)
//   rd_busy_o  : per-port "write still in flight" flag (combinational)
//   wr_en_i    : NWP write enables
//   wr_addr_i  : NWP packed write addresses
//   wr_data_i  : NWP packed write data
//   iss_en_i   : issue strobe, marks iss_addr_i busy
//   iss_addr_i : destination register of the issuing instruction
//   busy_cnt_o : number of busy registers (registered)
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  XLEN = DEF_XLEN,
    parameter int  NREG = DEF_NREG,
    parameter int  NRP  = 2,
    parameter int  NWP  = 2,
    localparam int AW   = clog2(NREG),
    localparam int CW   = clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic [NWP-1:0]      wr_en_i,
    input  logic [NWP*AW-1:0]   wr_addr_i,
    input  logic [NWP*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic [CW-1:0]       busy_cnt_o
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_nxt;
    logic            rise;
    logic [CW-1:0]   fall;
    logic [CW-1:0]   busy_cnt;
    logic [CW-1:0]   busy_cnt_nxt;

    // Set wins over clear so a same-cycle issue re-arms the register for the
    // new producer. The counter moves by the delta of bits that actually
    // change; register 0 is masked out of both set and clear.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        fall     = '0;
        for (int w = 0; w < NWP; w++) begin
            if (wr_en_i[w]) begin
                busy_clr[wr_addr_i[w*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en_i) begin
            busy_set[iss_addr_i] = 1'b1;
        end
        busy_set[0] = 1'b0;
        busy_clr[0] = 1'b0;
        busy_nxt    = (busy & ~busy_clr) | busy_set;
        rise        = |(busy_set & ~busy);
        for (int i = 0; i < NREG; i++) begin
            if (busy[i] && busy_clr[i] && !busy_set[i]) begin
                fall = fall + CW'(1);
            end
        end
        busy_cnt_nxt = busy_cnt + CW'(rise) - fall;
    end

    // Writes are applied in ascending port order, so the highest-index port
    // wins when several target the same address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                    mem[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    assign busy_cnt_o = busy_cnt;

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] fwd_data;
        logic            hit;

        assign ra = rd_addr_i[p*AW +: AW];

        regfile_sb_fwd #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWP  (NWP)
        ) u_fwd (
            .rd_addr  (ra),
            .arr_data (mem[ra]),
            .wr_en    (wr_en_i),
            .wr_addr  (wr_addr_i),
            .wr_data  (wr_data_i),
            .rd_data  (fwd_data),
            .hit      (hit)
        );

        // busy[0] is never set, so address 0 reads not-busy without a check.
        assign rd_data_o[p*XLEN +: XLEN] = rst ? fwd_data : '0;
        assign rd_busy_o[p]              = rst & busy[ra] & ~hit;
    end

endmodule
